// File: rtl/csr_defs.sv
// Shared CSR addresses, MSTATUS bit positions, trap causes and
// trap sequencer state encoding.
package csr_defs;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] CAUSE_M_EXT_IRQ = 32'h8000000B;
  localparam logic [1:0]  MTVEC_VECTORED  = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CSR_ISSUE,
    S_CSR_ACK,
    S_T_RD_STATUS,
    S_T_WR_EPC,
    S_T_WR_CAUSE,
    S_T_WR_TVAL,
    S_T_WR_STATUS,
    S_T_RD_TVEC,
    S_M_RD_EPC,
    S_M_RD_STATUS,
    S_M_WR_STATUS,
    S_REDIRECT
  } ts_state_e;

  function automatic logic [31:0] trap_status(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE] = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_status(
    input logic [31:0] s
  );
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE] = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectored mode applies to interrupts only; modes 2/3 fall back to direct.
  function automatic logic [31:0] trap_target(
    input logic [31:0] tvec,
    input logic [31:0] cause,
    input logic        vec_en
  );
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if (vec_en && tvec[1:0] == MTVEC_VECTORED && cause[31])
      return base + {25'd0, cause[4:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/csr_write_step.sv
// Issue/ack handshake for one CSR write: one issue cycle, then wait
// for the CSR unit's write_done.
module csr_write_step (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic done,
  output logic issue,
  output logic finish
);

  logic phase_q;
  logic phase_d;

  assign issue  = active & ~phase_q;
  assign finish = active & phase_q & done;

  always_comb begin
    phase_d = phase_q;
    if (!active || finish)
      phase_d = 1'b0;
    else
      phase_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      phase_q <= 1'b0;
    else
      phase_q <= phase_d;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Owns the CSR port: pipeline CSR writes, trap entry and MRET
// sequences, ending in a one-cycle redirect/flush.
module trap_sequencer
  import csr_defs::*;
#(
  parameter logic [31:0] IRQ_CAUSE   = CAUSE_M_EXT_IRQ,
  parameter bit          VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_valid,
  input  logic [31:0] exception_cause,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_tval,
  input  logic        mret_valid,
  input  logic        irq_pending,
  input  logic [31:0] irq_pc,
  output logic        trap_ack,
  input  logic        csr_req_valid,
  output logic        csr_req_ready,
  input  logic [11:0] csr_req_addr,
  input  logic [31:0] csr_req_wdata,
  output logic [31:0] csr_req_rdata,
  output logic        csr_req_done,
  output logic        csr_write_enable,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_write_done,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  ts_state_e   state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] status_q, status_d;
  logic [31:0] target_q, target_d;
  logic        mie_q, mie_d;

  logic wr_active;
  logic wr_issue;
  logic wr_finish;

  assign wr_active = state_q inside {S_T_WR_EPC, S_T_WR_CAUSE,
                                     S_T_WR_TVAL, S_T_WR_STATUS,
                                     S_M_WR_STATUS};

  csr_write_step u_wr (
    .clk    (clk),
    .reset  (reset),
    .active (wr_active),
    .done   (csr_write_done),
    .issue  (wr_issue),
    .finish (wr_finish)
  );

  assign csr_req_rdata = csr_rdata;
  assign redirect_pc   = target_q;
  assign busy          = state_q != S_IDLE;

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    tval_d           = tval_q;
    status_d         = status_q;
    target_d         = target_q;
    mie_d            = mie_q;
    trap_ack         = 1'b0;
    csr_req_ready    = 1'b0;
    csr_req_done     = 1'b0;
    csr_write_enable = 1'b0;
    csr_addr         = csr_req_addr;
    csr_wdata        = csr_req_wdata;
    redirect_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exception_valid) begin
          trap_ack = 1'b1;
          cause_d  = exception_cause;
          epc_d    = exception_pc;
          tval_d   = exception_tval;
          state_d  = S_T_RD_STATUS;
        end else if (mret_valid) begin
          trap_ack = 1'b1;
          state_d  = S_M_RD_EPC;
        end else if (irq_pending && mie_q) begin
          trap_ack = 1'b1;
          cause_d  = IRQ_CAUSE;
          epc_d    = irq_pc;
          tval_d   = '0;
          state_d  = S_T_RD_STATUS;
        end else begin
          csr_req_ready = 1'b1;
          if (csr_req_valid) begin
            csr_write_enable = 1'b1;
            state_d = S_CSR_ACK;
            if (csr_req_addr == CSR_MSTATUS)
              mie_d = csr_req_wdata[MSTATUS_MIE];
          end
        end
      end
      S_CSR_ACK: begin
        if (csr_write_done) begin
          csr_req_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_T_RD_STATUS: begin
        csr_addr = CSR_MSTATUS;
        status_d = csr_rdata;
        state_d  = S_T_WR_EPC;
      end
      S_T_WR_EPC: begin
        csr_addr  = CSR_MEPC;
        csr_wdata = epc_q;
        csr_write_enable = wr_issue;
        if (wr_finish) state_d = S_T_WR_CAUSE;
      end
      S_T_WR_CAUSE: begin
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        csr_write_enable = wr_issue;
        if (wr_finish) state_d = S_T_WR_TVAL;
      end
      S_T_WR_TVAL: begin
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_q;
        csr_write_enable = wr_issue;
        if (wr_finish) state_d = S_T_WR_STATUS;
      end
      S_T_WR_STATUS: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = trap_status(status_q);
        csr_write_enable = wr_issue;
        if (wr_issue) mie_d = csr_wdata[MSTATUS_MIE];
        if (wr_finish) state_d = S_T_RD_TVEC;
      end
      S_T_RD_TVEC: begin
        csr_addr = CSR_MTVEC;
        target_d = trap_target(csr_rdata, cause_q,
                               VECTORED_EN);
        state_d  = S_REDIRECT;
      end
      S_M_RD_EPC: begin
        csr_addr = CSR_MEPC;
        target_d = {csr_rdata[31:1], 1'b0};
        state_d  = S_M_RD_STATUS;
      end
      S_M_RD_STATUS: begin
        csr_addr = CSR_MSTATUS;
        status_d = csr_rdata;
        state_d  = S_M_WR_STATUS;
      end
      S_M_WR_STATUS: begin
        csr_addr  = CSR_MSTATUS;
        csr_wdata = mret_status(status_q);
        csr_write_enable = wr_issue;
        if (wr_issue) mie_d = csr_wdata[MSTATUS_MIE];
        if (wr_finish) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      status_q <= '0;
      target_q <= '0;
      mie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      status_q <= status_d;
      target_q <= target_d;
      mie_q    <= mie_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer with a small CSR unit model
// (write_done one cycle after each write).
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        exception_valid = 1'b0;
  logic [31:0] exception_cause = '0;
  logic [31:0] exception_pc = '0;
  logic [31:0] exception_tval = '0;
  logic        mret_valid = 1'b0;
  logic        irq_pending = 1'b0;
  logic [31:0] irq_pc = '0;
  logic        trap_ack;
  logic        csr_req_valid = 1'b0;
  logic        csr_req_ready;
  logic [11:0] csr_req_addr = '0;
  logic [31:0] csr_req_wdata = '0;
  logic [31:0] csr_req_rdata;
  logic        csr_req_done;
  logic        csr_write_enable;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_write_done;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .exception_valid  (exception_valid),
    .exception_cause  (exception_cause),
    .exception_pc     (exception_pc),
    .exception_tval   (exception_tval),
    .mret_valid       (mret_valid),
    .irq_pending      (irq_pending),
    .irq_pc           (irq_pc),
    .trap_ack         (trap_ack),
    .csr_req_valid    (csr_req_valid),
    .csr_req_ready    (csr_req_ready),
    .csr_req_addr     (csr_req_addr),
    .csr_req_wdata    (csr_req_wdata),
    .csr_req_rdata    (csr_req_rdata),
    .csr_req_done     (csr_req_done),
    .csr_write_enable (csr_write_enable),
    .csr_addr         (csr_addr),
    .csr_wdata        (csr_wdata),
    .csr_rdata        (csr_rdata),
    .csr_write_done   (csr_write_done),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .busy             (busy)
  );

  // CSR unit model
  logic [31:0] m_status, m_epc, m_cause;
  logic [31:0] m_tval, m_tvec, m_scratch;
  logic        done_q;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_status  <= '0;
      m_epc     <= '0;
      m_cause   <= '0;
      m_tval    <= '0;
      m_tvec    <= '0;
      m_scratch <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= csr_write_enable;
      if (csr_write_enable) begin
        case (csr_addr)
          12'h300: m_status  <= csr_wdata;
          12'h305: m_tvec    <= csr_wdata;
          12'h340: m_scratch <= csr_wdata;
          12'h341: m_epc     <= csr_wdata;
          12'h342: m_cause   <= csr_wdata;
          12'h343: m_tval    <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign csr_write_done = done_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = m_status;
      12'h305: csr_rdata = m_tvec;
      12'h340: csr_rdata = m_scratch;
      12'h341: csr_rdata = m_epc;
      12'h342: csr_rdata = m_cause;
      12'h343: csr_rdata = m_tval;
      default: csr_rdata = '0;
    endcase
  end

  typedef struct {
    bit          is_redir;
    logic [31:0] pc;
    int          cyc;
    int          tol;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  // Monitor: pops expected events whenever the DUT presents one
  always @(negedge clk) begin
    exp_t e;
    if (reset && (redirect_valid || csr_req_done)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: redir=%0b done=%0b cyc=%0d want none",
                 redirect_valid, csr_req_done, cyc);
      end else begin
        e = q.pop_front();
        chk("event_is_redirect", 32'(redirect_valid),
            32'(e.is_redir));
        if (e.is_redir)
          chk("redirect_pc", redirect_pc, e.pc);
        tests++;
        if (cyc < e.cyc || cyc > e.cyc + e.tol) begin
          fails++;
          $display("FAIL event_cycle: got %0d want %0d..%0d",
                   cyc, e.cyc, e.cyc + e.tol);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    #1;
    while (busy && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic push_redir(input logic [31:0] pc,
                            input int at);
    exp_t e;
    e.is_redir = 1'b1;
    e.pc = pc;
    e.cyc = at;
    e.tol = 0;
    q.push_back(e);
  endtask

  task automatic push_done(input int at, input int tol);
    exp_t e;
    e.is_redir = 1'b0;
    e.pc = '0;
    e.cyc = at;
    e.tol = tol;
    q.push_back(e);
  endtask

  // Holds the request until accepted, then drops it
  task automatic hold_req_until_accept();
    int n = 0;
    while (!csr_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_accept_ready", 32'(csr_req_ready), 32'd1);
    @(negedge clk);
    csr_req_valid = 1'b0;
  endtask

  task automatic pipe_write(input logic [11:0] a,
                            input logic [31:0] d);
    wait_idle();
    csr_req_valid = 1'b1;
    csr_req_addr  = a;
    csr_req_wdata = d;
    #1;
    if (csr_req_ready) push_done(cyc + 1, 0);
    hold_req_until_accept();
  endtask

  task automatic do_trap(input logic exc, input logic mret,
                         input logic irq,
                         input logic [31:0] cause,
                         input logic [31:0] pc,
                         input logic [31:0] tval,
                         input logic [31:0] exp_pc,
                         input int lat);
    wait_idle();
    exception_valid = exc;
    exception_cause = cause;
    exception_pc    = pc;
    exception_tval  = tval;
    mret_valid      = mret;
    irq_pending     = irq;
    irq_pc          = pc;
    #1;
    chk("trap_ack", 32'(trap_ack), 32'd1);
    push_redir(exp_pc, cyc + lat);
    @(negedge clk);
    exception_valid = 1'b0;
    mret_valid      = 1'b0;
    irq_pending     = 1'b0;
    #1;
    chk("busy_after_ack", 32'(busy), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_we", 32'(csr_write_enable), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_ready", 32'(csr_req_ready), 32'd1);
    chk("idle_ack", 32'(trap_ack), 32'd0);

    // Exception into direct MTVEC
    pipe_write(12'h305, 32'h2000);
    do_trap(1'b1, 1'b0, 1'b0, 32'd2, 32'h100, 32'hDEAD,
            32'h2000, 11);
    wait_idle();
    chk("exc_mepc", m_epc, 32'h100);
    chk("exc_mcause", m_cause, 32'd2);
    chk("exc_mtval", m_tval, 32'hDEAD);
    chk("exc_mstatus", m_status, 32'h1800);

    // Interrupt into vectored MTVEC
    pipe_write(12'h300, 32'h8);
    pipe_write(12'h305, 32'h2001);
    wait_idle();
    csr_req_addr = 12'h305;
    #1;
    chk("req_rdata_mtvec", csr_req_rdata, 32'h2001);
    do_trap(1'b0, 1'b0, 1'b1, 32'd0, 32'h1234, 32'd0,
            32'h202C, 11);
    wait_idle();
    chk("irq_mcause", m_cause, 32'h8000000B);
    chk("irq_mepc", m_epc, 32'h1234);
    chk("irq_mtval", m_tval, 32'd0);
    chk("irq_mstatus", m_status, 32'h1880);

    // MRET
    pipe_write(12'h341, 32'h403);
    do_trap(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0,
            32'h402, 5);
    wait_idle();
    chk("mret_mstatus", m_status, 32'h1888);

    // Exception and CSR request in the same cycle
    wait_idle();
    exception_valid = 1'b1;
    exception_cause = 32'd5;
    exception_pc    = 32'h200;
    exception_tval  = 32'd0;
    csr_req_valid   = 1'b1;
    csr_req_addr    = 12'h340;
    csr_req_wdata   = 32'hCAFE;
    #1;
    chk("both_trap_ack", 32'(trap_ack), 32'd1);
    chk("both_req_ready", 32'(csr_req_ready), 32'd0);
    push_redir(32'h2000, cyc + 11);
    push_done(cyc + 13, 1);
    @(negedge clk);
    exception_valid = 1'b0;
    #1;
    hold_req_until_accept();
    wait_idle();
    chk("both_mscratch", m_scratch, 32'hCAFE);
    chk("both_mepc", m_epc, 32'h200);
    chk("both_mstatus", m_status, 32'h1880);

    // Interrupt masked by MIE=0: the CSR request wins
    pipe_write(12'h300, 32'h0);
    wait_idle();
    irq_pending   = 1'b1;
    irq_pc        = 32'h500;
    csr_req_valid = 1'b1;
    csr_req_addr  = 12'h340;
    csr_req_wdata = 32'h1111;
    #1;
    chk("masked_ack", 32'(trap_ack), 32'd0);
    chk("masked_ready", 32'(csr_req_ready), 32'd1);
    push_done(cyc + 1, 0);
    @(negedge clk);
    csr_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("masked_busy", 32'(busy), 32'd0);
    chk("masked_mscratch", m_scratch, 32'h1111);
    irq_pending = 1'b0;

    // Reset in the middle of a trap sequence
    wait_idle();
    exception_valid = 1'b1;
    exception_cause = 32'd7;
    exception_pc    = 32'h600;
    #1;
    chk("rst_trap_ack", 32'(trap_ack), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("rst_mid_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    exception_valid = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_mid_we", 32'(csr_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    pipe_write(12'h340, 32'h55);
    wait_idle();
    chk("post_rst_mscratch", m_scratch, 32'h55);

    repeat (3) @(negedge clk);
    chk("pending_events", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that owns the single CSR read/write port of the CSR unit and shares it between the pipeline's CSR instructions and the trap machinery. On exception, machine external interrupt or MRET, it sequences the required MSTATUS, MEPC, MCAUSE and MTVAL accesses, then issues a one-cycle PC redirect and flush to the fetch stage. It sits between the decode/execute control logic and the CSR unit.

## Interface
- IRQ_CAUSE, 32'h8000000B, mcause value written for an interrupt (machine external).
- VECTORED_EN, 1, 1 = honour MTVEC mode 1 for interrupts; 0 = all traps direct.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- exception_valid  in  1  level; held by pipeline until trap_ack.
- exception_cause  in  32  mcause value for the exception.
- exception_pc  in  32  faulting PC, written to MEPC.
- exception_tval  in  32  MTVAL value.
- mret_valid  in  1  level; held until trap_ack.
- irq_pending  in  1  external interrupt, already masked by MIE.MEIE.
- irq_pc  in  32  PC of next unretired instruction, written to MEPC on interrupt.
- trap_ack  out  1  combinational; high in the IDLE cycle a trap or MRET is accepted.
- csr_req_valid / csr_req_ready  in / out  1  pipeline CSR write handshake.
- csr_req_addr  in  12; csr_req_wdata  in  32.
- csr_req_rdata  out  32  combinational pass-through of csr_rdata.
- csr_req_done  out  1  one-cycle pulse when the pipeline write completes.
- csr_write_enable  out  1; csr_addr  out  12; csr_wdata  out  32  CSR unit port.
- csr_rdata  in  32  CSR unit combinational read data; csr_write_done  in  1.
- redirect_valid  out  1  one-cycle pulse, also the pipeline flush.
- redirect_pc  out  32.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, CSR_ISSUE, CSR_ACK, T_RD_STATUS, T_WR_EPC, T_WR_CAUSE, T_WR_TVAL, T_WR_STATUS, T_RD_TVEC, M_RD_EPC, M_RD_STATUS, M_WR_STATUS, REDIRECT. Each T_WR_*/M_WR_* state has an issue and an ack sub-cycle.
- Write step: issue cycle has write_enable=1 with addr/data. The following cycles have write_enable=0 and wait for csr_write_done=1; the step advances on the cycle csr_write_done is seen. Read step: one cycle with csr_addr driven; csr_rdata is latched at the clock edge.
- IDLE priority: exception > mret > interrupt (irq_pending & mie_shadow) > csr_req. csr_req_ready=1 only in IDLE when none of the higher-priority requests is active. In IDLE, csr_addr=csr_req_addr, so pipeline reads are combinational.
- Trap entry: latch cause/pc/tval (interrupt: IRQ_CAUSE, irq_pc, 0). Read MSTATUS, then write MEPC, MCAUSE and MTVAL.
- Trap MSTATUS write: bit7 (MPIE) takes the old bit3, bit3 (MIE) is cleared, bits 12:11 (MPP) are set to 2'b11. Then read MTVEC.
- Trap redirect_pc: {tvec[31:2],2'b00}, plus {cause[4:0],2'b00} if VECTORED_EN, tvec[1:0]=1 and cause[31]=1. Modes 2/3 are treated as direct.
- MRET: read MEPC, read MSTATUS. Write MSTATUS with MIE set to old MPIE, MPIE set to 1, MPP set to 2'b11. redirect_pc={mepc[31:1],1'b0}.
- mie_shadow mirrors MSTATUS bit3. It is updated on every MSTATUS write this block issues, including pipeline writes to 0x300, and is reset to 0.
- Arithmetic is modulo 2^32; vectored offset overflow wraps.

## Timing
- Reset values: all registered outputs are 0, state is IDLE, mie_shadow is 0, latches are 0. Reset is asynchronous and aborts any sequence; a partially written CSR set is acceptable because the CSR unit resets too.
- Trap accepted at T0. T1: RD_STATUS. T2/T3: EPC. T4/T5: CAUSE. T6/T7: TVAL. T8/T9: STATUS. T10: RD_TVEC. T11: redirect_valid=1. T12: IDLE. Total 11 cycles with a write_done latency of 1.
- MRET accepted at T0. T1: RD_EPC. T2: RD_STATUS. T3/T4: write. T5: redirect. T6: IDLE.
- CSR request accepted at T0 (write_enable=1 in the same cycle). T1: ack, csr_req_done=1. T2: IDLE.
- Requests arriving while busy are ignored until IDLE; levels must be held. An irq that drops before acceptance is not taken.

## Structure
- Shared package/include csr_defs: CSR address constants, MSTATUS bit positions (MIE=3, MPIE=7, MPP=12:11), cause constants, state encoding.
- Optional sub-module csr_write_step: issue/ack handshake, reused by all write states.

## Test plan
- Exception, cause 2, pc 0x100, tval 0xDEAD, MTVEC 0x2000 -> MEPC=0x100, MCAUSE=2, MTVAL=0xDEAD, MSTATUS.MIE=0, redirect_pc=0x2000 at T11.
- Pipeline sets MSTATUS=0x8, MTVEC=0x2001, then irq_pending -> MCAUSE=0x8000000B, MPIE=1, redirect_pc=0x202C.
- MRET with MEPC=0x403, MPIE=1 -> MIE=1, redirect_pc=0x402 at T5.
- exception_valid and csr_req_valid in the same cycle -> trap_ack=1, csr_req_ready=0; CSR request completes at T13/T14.
- irq_pending=1 with MSTATUS=0 -> no trap; csr_req is served normally.
- reset asserted at T5 of a trap -> busy=0 and redirect_valid=0 immediately; IDLE after release.
